// File: rtl/nes_audio_i2s_tx.sv
// nes_audio_i2s_tx
// Output stage of the NES APU audio path. Filtered 16-bit samples arrive on a
// one-cycle strobe and are buffered in a small FIFO. They leave as
// Philips-format I2S, with the mono sample sent in both the left and the right slot.
//
// Parameters
//   CLK_DIV      clk cycles per BCLK half-period (>= 1)
//   FIFO_DEPTH   sample FIFO entries (power of two, >= 2)
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   sample_in     signed 16-bit sample from the FIR stage
//   sample_valid  one-cycle write strobe
//   i2s_bclk      bit clock
//   i2s_lrck      word select (0 = left, 1 = right)
//   i2s_sdata     serial data, MSB first, one-bit delayed from lrck
//   fifo_level    current FIFO occupancy
//   underrun      one-cycle pulse: FIFO empty at frame load
//   overflow      one-cycle pulse: write dropped, FIFO full
//
// Build option
//   I2S_UNDERRUN_HOLD_EN  when defined, an underrun repeats the last word;
//                         otherwise an underrun frame carries silence.

module nes_audio_i2s_tx #(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [15:0]                        sample_in,
    input  logic                               sample_valid,
    output logic                               i2s_bclk,
    output logic                               i2s_lrck,
    output logic                               i2s_sdata,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic                               underrun,
    output logic                               overflow
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam logic [DW-1:0] DIV_TC = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic [4:0]    slot;
    logic [4:0]    slot_nxt;
    logic [3:0]    bit_idx;
    logic [15:0]   word;
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    logic fall_evt;
    logic pop_evt;
    logic empty;
    logic full;
    logic do_pop;
    logic do_push;

    assign fall_evt = i2s_bclk && (div_cnt == DIV_TC);
    assign slot_nxt = slot + 5'd1;
    assign pop_evt  = fall_evt && (slot_nxt == 5'd0);

    // Slots 1..15 carry W[16-b] and 17..31 carry W[32-b]; slot 16 carries W[0].
    // Both fold into (16 - b) mod 16 on the low four slot bits.
    assign bit_idx  = 4'd0 - slot_nxt[3:0];

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop_evt && !empty;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign do_push = sample_valid && (!full || do_pop);

    assign fifo_level = LW'(wr_ptr - rd_ptr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            i2s_bclk <= 1'b0;
        end else if (div_cnt == DIV_TC) begin
            div_cnt  <= '0;
            i2s_bclk <= ~i2s_bclk;
        end else begin
            div_cnt  <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot      <= 5'd31;
            i2s_lrck  <= 1'b1;
            i2s_sdata <= 1'b0;
            word      <= '0;
            underrun  <= 1'b0;
        end else begin
            underrun <= pop_evt && empty;
            if (fall_evt) begin
                slot <= slot_nxt;
                if (slot_nxt == 5'd0) begin
                    i2s_lrck  <= 1'b0;
                    // The outgoing word still sits in W here, so its LSB is the
                    // delayed right-channel bit for this slot.
                    i2s_sdata <= word[0];
                    if (!empty) begin
                        word <= mem[rd_ptr[AW-1:0]];
                    end else begin
`ifdef I2S_UNDERRUN_HOLD_EN
                        word <= word;
`else
                        word <= '0;
`endif
                    end
                end else begin
                    if (slot_nxt == 5'd16) begin
                        i2s_lrck <= 1'b1;
                    end
                    i2s_sdata <= word[bit_idx];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= sample_valid && !do_push;
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= sample_in;
        end
    end

endmodule

// File: tb/tb_nes_audio_i2s_tx.sv
// Testbench for nes_audio_i2s_tx (CLK_DIV=2, FIFO_DEPTH=4).
// A cycle-count reference model predicts every output after every clk edge.
// Directed steps cover serialisation, underrun, overflow and push/pop
// coincidences, followed by random traffic and a mid-frame reset.

module tb_nes_audio_i2s_tx;

    localparam int CD    = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        i2s_bclk;
    logic        i2s_lrck;
    logic        i2s_sdata;
    logic [2:0]  fifo_level;
    logic        underrun;
    logic        overflow;

    nes_audio_i2s_tx #(.CLK_DIV(CD), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrck     (i2s_lrck),
        .i2s_sdata    (i2s_sdata),
        .fifo_level   (fifo_level),
        .underrun     (underrun),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          n = 0;
    logic [15:0] q[$];
    logic [15:0] m_w = '0;
    logic        m_bclk = 1'b0;
    logic        m_lrck = 1'b1;
    logic        m_sdata = 1'b0;
    logic        m_ur = 1'b0;
    logic        m_ov = 1'b0;
    logic [15:0] left_cap = '0;
    logic [15:0] right_cap = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h at model cycle %0d", tag, obs, exp, n);
        end
    endtask

    function automatic bit is_event(input int k);
        return (k > 0) && ((k % (2 * CD)) == 0);
    endfunction

    function automatic int slot_of(input int k);
        return ((k / (2 * CD)) - 1) % 32;
    endfunction

    function automatic int frame_of(input int k);
        return ((k / (2 * CD)) - 1) / 32;
    endfunction

    task automatic model_reset();
        n       = 0;
        q.delete();
        m_w     = '0;
        m_bclk  = 1'b0;
        m_lrck  = 1'b1;
        m_sdata = 1'b0;
        m_ur    = 1'b0;
        m_ov    = 1'b0;
    endtask

    // One rising edge of the reference: frame load first, then the write.
    task automatic model_edge(input logic sv, input logic [15:0] d);
        int s;
        n++;
        m_ur   = 1'b0;
        m_ov   = 1'b0;
        m_bclk = ((n / CD) % 2) == 1;
        if (is_event(n)) begin
            s = slot_of(n);
            if (s == 0) begin
                m_sdata = m_w[0];
                m_lrck  = 1'b0;
                if (q.size() == 0) begin
                    m_ur = 1'b1;
`ifndef I2S_UNDERRUN_HOLD_EN
                    m_w = '0;
`endif
                end else begin
                    m_w = q.pop_front();
                end
            end else if (s <= 16) begin
                m_sdata = m_w[16 - s];
                if (s == 16) m_lrck = 1'b1;
            end else begin
                m_sdata = m_w[32 - s];
            end
        end
        if (sv) begin
            if (q.size() < DEPTH) q.push_back(d);
            else m_ov = 1'b1;
        end
    endtask

    task automatic check_all();
        check("bclk",     32'(i2s_bclk),   32'(m_bclk));
        check("lrck",     32'(i2s_lrck),   32'(m_lrck));
        check("sdata",    32'(i2s_sdata),  32'(m_sdata));
        check("level",    32'(fifo_level), 32'(q.size()));
        check("underrun", 32'(underrun),   32'(m_ur));
        check("overflow", 32'(overflow),   32'(m_ov));
    endtask

    task automatic step(input logic sv, input logic [15:0] d);
        int s;
        sample_valid = sv;
        sample_in    = d;
        @(posedge clk);
        model_edge(sv, d);
        #1;
        sample_valid = 1'b0;
        check_all();
        if (is_event(n)) begin
            s = slot_of(n);
            if (frame_of(n) == 0 && s >= 1 && s <= 16) left_cap = {left_cap[14:0], i2s_sdata};
            if (frame_of(n) == 0 && s >= 17) right_cap = {right_cap[14:0], i2s_sdata};
            if (frame_of(n) == 1 && s == 0) right_cap = {right_cap[14:0], i2s_sdata};
        end
    endtask

    task automatic run_to_pop_edge();
        int guard;
        guard = 0;
        while (!(is_event(n + 1) && slot_of(n + 1) == 0)) begin
            step(1'b0, 16'h0000);
            guard++;
            if (guard > 70 * CD) begin
                check("pop_edge_timeout", 32'(guard), 32'(0));
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_bclk",     32'(i2s_bclk),   32'(0));
        check("rst_lrck",     32'(i2s_lrck),   32'(1));
        check("rst_sdata",    32'(i2s_sdata),  32'(0));
        check("rst_level",    32'(fifo_level), 32'(0));
        check("rst_underrun", 32'(underrun),   32'(0));
        check("rst_overflow", 32'(overflow),   32'(0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        do_reset();

        // Serialisation of 16'hA55A in frame 0, 16'h7FFF queued for frame 1.
        step(1'b1, 16'hA55A);
        for (int i = 0; i < 8; i++) step(1'b0, 16'h0000);
        step(1'b1, 16'h7FFF);
        while (n < 4 * CD * 16 + 2 * CD + 1) step(1'b0, 16'h0000);
        check("left_word",  32'(left_cap),  32'(16'hA55A));
        check("right_word", 32'(right_cap), 32'(16'hA55A));

        // Frame 2 load finds the FIFO empty.
        run_to_pop_edge();
        step(1'b0, 16'h0000);
        check("underrun_f2", 32'(underrun), 32'(1));

        // Six back-to-back strobes between pops: four stored, two dropped.
        for (int i = 0; i < 6; i++) step(1'b1, 16'(16'h1000 + i));
        check("level_full", 32'(fifo_level), 32'(4));

        // Strobe on the pop cycle of a full FIFO.
        run_to_pop_edge();
        step(1'b1, 16'hBEEF);
        check("full_coinc_level", 32'(fifo_level), 32'(4));
        check("full_coinc_ovf",   32'(overflow),   32'(0));

        // Drain the FIFO, then strobe on the pop cycle of an empty FIFO.
        for (int i = 0; i < 4; i++) begin
            run_to_pop_edge();
            step(1'b0, 16'h0000);
        end
        run_to_pop_edge();
        step(1'b1, 16'h1234);
        check("empty_coinc_ur",    32'(underrun),   32'(1));
        check("empty_coinc_level", 32'(fifo_level), 32'(1));
        run_to_pop_edge();
        step(1'b0, 16'h0000);

        // Random traffic at a few write rates around the frame rate.
        for (int i = 0; i < 1500; i++) step($urandom_range(0, 99) < 1, 16'($urandom));
        for (int i = 0; i < 1500; i++) step($urandom_range(0, 99) < 3, 16'($urandom));

        // Mid-frame asynchronous reset, then more traffic.
        for (int i = 0; i < 37; i++) step($urandom_range(0, 9) < 3, 16'($urandom));
        do_reset();
        for (int i = 0; i < 800; i++) step($urandom_range(0, 99) < 2, 16'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
